// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data memory between a CPU and a DMA port with starvation-bounded CPU priority
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic        dma_stall,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        owner
);
   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
   state_t state, state_nx;
   logic we_q;
   logic [3:0] starve_cnt;
   logic any_req, dma_win;
   assign any_req   = cpu_req | dma_req;
   assign dma_win   = dma_req & ~(cpu_req & (starve_cnt < 4'(STARVE_MAX)));
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign dma_stall = dma_req & ~dma_ack;
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   // next state and memory/ack strobes; request inputs are ignored outside IDLE
   always_comb begin
      state_nx = state;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      cpu_ack  = 1'b0;
      dma_ack  = 1'b0;
      case (state)
         IDLE:    state_nx = any_req ? ACCESS : IDLE;
         ACCESS: begin
            state_nx = ACK;
            mem_rd   = ~we_q;
            mem_wr   = we_q;
         end
         ACK: begin
            state_nx = IDLE;
            cpu_ack  = ~owner;
            dma_ack  = owner;
         end
         default: state_nx = IDLE;
      endcase
   end
   // latch the winner's request at grant so a dropped request still completes unchanged
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         owner      <= 1'b0;
         we_q       <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         starve_cnt <= '0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            owner     <= dma_win;
            we_q      <= dma_win ? dma_we : cpu_we;
            mem_addr  <= dma_win ? dma_addr : cpu_addr;
            mem_wdata <= dma_win ? dma_wdata : cpu_wdata;
            if (dma_win)
               starve_cnt <= '0;
            else if (dma_req && starve_cnt < 4'(STARVE_MAX))
               starve_cnt <= starve_cnt + 4'd1;
         end
         if (state == ACCESS && !we_q) begin
            if (owner) dma_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
         end
      end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles DMA may be denied before forced DMA grant (legal range 1..15).
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk and reset; all state changes on posedge clk.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 cpu_req / cpu_we  in  1/1  CPU data-port request / write-enable; held until cpu_ack.
REQ-006 cpu_addr / cpu_wdata  in  32/32  CPU byte address / write data; held until cpu_ack.
REQ-007 cpu_rdata  out  32  registered read data; valid while cpu_ack=1.
REQ-008 cpu_ack / cpu_stall  out  1/1  one-cycle completion pulse / pipeline freeze, = cpu_req & ~cpu_ack.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: DMA requester port, same widths and rules as CPU port.
REQ-010 mem_rd / mem_wr  out  1/1  single-cycle read / write strobe to the shared data memory.
REQ-011 mem_addr / mem_wdata  out  32/32  address / write data to memory.
REQ-012 mem_rdata  in  32  combinational memory read data, valid in the same cycle as mem_rd.
REQ-013 owner  out  1  0 = CPU, 1 = DMA; requester of the current or last transaction.

Function
REQ-014 SHALL implement FSM IDLE, ACCESS, ACK; each transaction takes exactly 3 cycles (IDLE->ACCESS->ACK->IDLE).
REQ-015 IDLE: if no request, stay; else select a winner, latch owner, go to ACCESS.
REQ-016 Selection: CPU wins if cpu_req and starve_cnt < STARVE_MAX; otherwise DMA wins if dma_req; otherwise CPU.
REQ-017 ACCESS: drive mem_addr/mem_wdata from the winner's port; mem_wr = winner_we, mem_rd = ~winner_we; register mem_rdata into the winner's rdata register at the clock edge; go to ACK.
REQ-018 mem_rd and mem_wr SHALL be 0 in every state except ACCESS, and never both 1.
REQ-019 ACK: pulse the winner's ack for exactly one cycle; the other ack stays 0; always go to IDLE (ignore reqs in ACK).
REQ-020 The rdata register SHALL hold its value until the next read by the same requester; writes leave it unchanged.
REQ-021 starve_cnt (4 bit) SHALL increment on each IDLE cycle where dma_req=1 and the CPU wins, saturate at STARVE_MAX, and clear when DMA wins.
REQ-022 A request dropped before its ack is a protocol error; the in-flight transaction SHALL still complete unchanged.
REQ-023 mem_addr/mem_wdata outside ACCESS SHALL hold the last driven value (no X).

Reset
REQ-024 On reset: state=IDLE, cpu_ack=dma_ack=0, mem_rd=mem_wr=0, cpu_rdata=dma_rdata=0, mem_addr=mem_wdata=0, owner=0, starve_cnt=0.
REQ-025 Reset asserted in ACCESS or ACK SHALL abort the transaction with no ack; after release the FSM restarts in IDLE and re-arbitrates held requests.

Verification
REQ-026 CPU read only: cpu_req=1, we=0, addr=0x10, mem_rdata=0xDEADBEEF -> mem_rd=1 at cycle 1, cpu_ack=1 with cpu_rdata=0xDEADBEEF at cycle 2, cpu_stall=1 at cycles 0-1.
REQ-027 Simultaneous: cpu_req and dma_req both rise in the same cycle with starve_cnt=0 -> CPU served first (owner=0), DMA acked 3 cycles later (owner=1).
REQ-028 Starvation: cpu_req held high continuously with dma_req=1 -> exactly 4 CPU transactions, then 1 DMA transaction, then starve_cnt=0 and CPU resumes.
REQ-029 DMA write: dma_we=1, addr=0x40000020, wdata=0x55 -> mem_wr=1 with those values for one cycle, dma_ack pulse, dma_rdata unchanged.
REQ-030 Reset mid-ACCESS -> all outputs reach REQ-024 values asynchronously, no ack; after release the held cpu_req completes in 3 cycles.
REQ-031 Throughout all scenarios, assert mem_rd&mem_wr==0, at most one ack high, and no ack without a prior request.
